// File: rtl/acc_clk_pkg.sv
// Shared constants and helpers for the phase-accumulator rate generator.
package acc_clk_pkg;

    localparam int unsigned DEF_ACC_SIZE = 16;
    localparam int unsigned DEF_OVS      = 16;
    localparam int unsigned DEF_FCW_RST  = 151;

    // Clock-output shaping mode; only the 50% duty form is implemented today.
    typedef enum logic [0:0] {
        CLK_MODE_DUTY50 = 1'b0,
        CLK_MODE_PULSE  = 1'b1
    } clk_mode_e;

    // Round-to-nearest FCW for a target baud rate at the default oversample ratio.
    function automatic longint unsigned calc_fcw(
        input longint unsigned fclk_hz,
        input longint unsigned fout_hz,
        input int unsigned     acc_size
    );
        longint unsigned num;
        num = (fout_hz * longint'(DEF_OVS)) << acc_size;
        return (num + fclk_hz / 2) / fclk_hz;
    endfunction

    localparam int unsigned FCW_50M_9600    = 32'(calc_fcw(64'd50_000_000,  64'd9600,   DEF_ACC_SIZE));
    localparam int unsigned FCW_50M_115200  = 32'(calc_fcw(64'd50_000_000,  64'd115200, DEF_ACC_SIZE));
    localparam int unsigned FCW_100M_9600   = 32'(calc_fcw(64'd100_000_000, 64'd9600,   DEF_ACC_SIZE));
    localparam int unsigned FCW_100M_115200 = 32'(calc_fcw(64'd100_000_000, 64'd115200, DEF_ACC_SIZE));

endpackage

// File: rtl/acc_baud_gen_if.sv
// FCW load handshake between the register interface and the rate generator.
interface acc_baud_gen_if import acc_clk_pkg::*; #(
    parameter int unsigned ACC_SIZE = DEF_ACC_SIZE
) ();

    logic [ACC_SIZE-1:0] fcw_i;
    logic                fcw_valid_i;
    logic                fcw_ready_o;

    modport master (
        output fcw_i,
        output fcw_valid_i,
        input  fcw_ready_o
    );

    modport slave (
        input  fcw_i,
        input  fcw_valid_i,
        output fcw_ready_o
    );

endinterface

// File: rtl/acc_phase_core.sv
// Phase accumulator with a shadowed FCW that switches only at overflow.
module acc_phase_core import acc_clk_pkg::*; #(
    parameter int unsigned ACC_SIZE = DEF_ACC_SIZE,
    parameter int unsigned FCW_RST  = DEF_FCW_RST
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                en_i,
    input  logic                phase_clr_i,
    input  logic [ACC_SIZE-1:0] fcw_i,
    input  logic                fcw_valid_i,
    output logic                fcw_ready_o,
    output logic                carry_o,
    output logic [ACC_SIZE-1:0] fcw_o
);

    localparam logic [ACC_SIZE-1:0] FCW_INIT = ACC_SIZE'(FCW_RST);
    localparam logic [ACC_SIZE-1:0] FCW_HALF = {1'b1, {(ACC_SIZE-1){1'b0}}};

    logic [ACC_SIZE-1:0] acc_q;
    logic [ACC_SIZE-1:0] fcw_q;
    logic [ACC_SIZE-1:0] shadow_q;
    logic                pending_q;
    logic [ACC_SIZE:0]   sum;
    logic                carry;
    logic                accept;
    logic                apply;

    // Next phase, overflow, and when the shadow word may take effect.
    always_comb begin
        sum    = {1'b0, acc_q} + {1'b0, fcw_q};
        carry  = en_i & sum[ACC_SIZE];
        accept = fcw_valid_i & ~pending_q;
        // A zero FCW never overflows, so it must not block its own replacement.
        apply  = pending_q & (phase_clr_i | ~en_i | carry | (fcw_q == '0));
    end

    // Accumulator, active FCW and shadow/handshake state.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            acc_q     <= '0;
            fcw_q     <= FCW_INIT;
            shadow_q  <= '0;
            pending_q <= 1'b0;
        end else begin
            if (phase_clr_i) begin
                acc_q <= '0;
            end else if (en_i) begin
                acc_q <= sum[ACC_SIZE-1:0];
            end
            if (apply) begin
                fcw_q     <= shadow_q;
                pending_q <= 1'b0;
            end else if (accept) begin
                shadow_q  <= fcw_i;
                pending_q <= 1'b1;
            end
        end
    end

    // Words above half scale make overflow ticks run back-to-back.
    assert property (@(posedge clk_i) disable iff (!rst_ni) fcw_q <= FCW_HALF);

    assign fcw_ready_o = ~pending_q;
    assign carry_o     = carry;
    assign fcw_o       = fcw_q;

endmodule

// File: rtl/acc_baud_gen.sv
// Oversample tick, baud tick and baud clock derived from the phase core.
module acc_baud_gen import acc_clk_pkg::*; #(
    parameter int unsigned ACC_SIZE = DEF_ACC_SIZE,
    parameter int unsigned OVS      = DEF_OVS,
    parameter int unsigned FCW_RST  = DEF_FCW_RST
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                en_i,
    input  logic                phase_clr_i,
    acc_baud_gen_if.slave       fcw_if,
    output logic [ACC_SIZE-1:0] fcw_o,
    output logic                ovs_tick_o,
    output logic                baud_tick_o,
    output logic                clk_o
);

    localparam int unsigned      CNT_W    = $clog2(OVS);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(OVS - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVS / 2);

    logic             carry;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_nxt;

    acc_phase_core #(
        .ACC_SIZE (ACC_SIZE),
        .FCW_RST  (FCW_RST)
    ) u_core (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .en_i        (en_i),
        .phase_clr_i (phase_clr_i),
        .fcw_i       (fcw_if.fcw_i),
        .fcw_valid_i (fcw_if.fcw_valid_i),
        .fcw_ready_o (fcw_if.fcw_ready_o),
        .carry_o     (carry),
        .fcw_o       (fcw_o)
    );

    // Oversample counter advances once per accumulator overflow.
    always_comb begin
        cnt_nxt = cnt_q;
        if (carry) begin
            cnt_nxt = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
        end
    end

    // Registered tick and clock outputs; phase clear takes priority over a carry.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q       <= '0;
            ovs_tick_o  <= 1'b0;
            baud_tick_o <= 1'b0;
            clk_o       <= 1'b1;
        end else if (phase_clr_i) begin
            cnt_q       <= '0;
            ovs_tick_o  <= 1'b0;
            baud_tick_o <= 1'b0;
            clk_o       <= 1'b1;
        end else if (!en_i) begin
            ovs_tick_o  <= 1'b0;
            baud_tick_o <= 1'b0;
        end else begin
            cnt_q       <= cnt_nxt;
            ovs_tick_o  <= carry;
            baud_tick_o <= carry && (cnt_q == CNT_MAX);
            clk_o       <= (cnt_nxt < CNT_HALF);
        end
    end

endmodule

// File: tb/tb_acc_baud_gen.sv
// Bench for acc_baud_gen: small instance under directed and random stimulus,
// large instance free-running for long-term rate accuracy.
module tb_acc_baud_gen;

    localparam int unsigned S_N   = 8;
    localparam int unsigned S_OVS = 4;
    localparam int unsigned S_RST = 64;
    localparam int unsigned B_N   = 16;
    localparam int unsigned B_OVS = 16;
    localparam int unsigned B_RST = 151;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           s_rst_n, s_en, s_clr;
    logic [S_N-1:0] s_fcw_o;
    logic           s_ovs, s_baud, s_clko;
    logic           b_rst_n;
    logic [B_N-1:0] b_fcw_o;
    logic           b_ovs, b_baud, b_clko;

    acc_baud_gen_if #(.ACC_SIZE(S_N)) s_if ();
    acc_baud_gen_if #(.ACC_SIZE(B_N)) b_if ();

    acc_baud_gen #(.ACC_SIZE(S_N), .OVS(S_OVS), .FCW_RST(S_RST)) u_small (
        .clk_i       (clk),
        .rst_ni      (s_rst_n),
        .en_i        (s_en),
        .phase_clr_i (s_clr),
        .fcw_if      (s_if),
        .fcw_o       (s_fcw_o),
        .ovs_tick_o  (s_ovs),
        .baud_tick_o (s_baud),
        .clk_o       (s_clko)
    );

    acc_baud_gen #(.ACC_SIZE(B_N), .OVS(B_OVS), .FCW_RST(B_RST)) u_big (
        .clk_i       (clk),
        .rst_ni      (b_rst_n),
        .en_i        (1'b1),
        .phase_clr_i (1'b0),
        .fcw_if      (b_if),
        .fcw_o       (b_fcw_o),
        .ovs_tick_o  (b_ovs),
        .baud_tick_o (b_baud),
        .clk_o       (b_clko)
    );

    int errors = 0;
    int checks = 0;
    int seen_ovs, seen_baud;

    // Reference model state: phase, active/shadow word, ticks since last clear.
    int m_acc, m_fcw, m_shadow, m_ticks;
    bit m_pend, m_ovs, m_baud;

    // Large-instance observation counters.
    int b_edges = 0;
    int b_ovs_seen = 0;
    int b_baud_seen = 0;

    always @(posedge clk) if (b_rst_n) b_edges <= b_edges + 1;
    always @(negedge clk) begin
        if (b_ovs === 1'b1)  b_ovs_seen  <= b_ovs_seen + 1;
        if (b_baud === 1'b1) b_baud_seen <= b_baud_seen + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input bit rn, input bit en, input bit clr, input bit vld, input int w);
        bit carry, apply, ready;
        if (!rn) begin
            m_acc = 0; m_fcw = S_RST; m_pend = 0; m_ticks = 0; m_ovs = 0; m_baud = 0;
        end else begin
            ready = !m_pend;
            carry = en && (m_acc + m_fcw >= (1 << S_N));
            apply = m_pend && (clr || !en || carry || m_fcw == 0);
            if (clr) begin
                m_acc = 0; m_ticks = 0; m_ovs = 0; m_baud = 0;
            end else if (!en) begin
                m_ovs = 0; m_baud = 0;
            end else begin
                m_acc = (m_acc + m_fcw) % (1 << S_N);
                m_ovs = carry;
                if (carry) m_ticks++;
                m_baud = carry && (m_ticks % S_OVS == 0);
            end
            if (apply) begin
                m_fcw = m_shadow; m_pend = 0;
            end else if (vld && ready) begin
                m_shadow = w; m_pend = 1;
            end
        end
    endtask

    task automatic cyc(input bit rn, input bit en, input bit clr, input bit vld, input int w);
        s_rst_n = rn; s_en = en; s_clr = clr;
        s_if.fcw_valid_i = vld;
        s_if.fcw_i = w[S_N-1:0];
        @(posedge clk);
        model_edge(rn, en, clr, vld, w);
        @(negedge clk);
        if (s_ovs === 1'b1)  seen_ovs++;
        if (s_baud === 1'b1) seen_baud++;
        chk("ovs_tick", s_ovs, m_ovs);
        chk("baud_tick", s_baud, m_baud);
        chk("clk_o", s_clko, (m_ticks % S_OVS) < S_OVS / 2);
        chk("fcw_o", s_fcw_o, m_fcw);
        chk("fcw_ready", s_if.fcw_ready_o, !m_pend);
    endtask

    initial begin
        int exp_ovs;
        s_rst_n = 1'b0; s_en = 1'b0; s_clr = 1'b0; b_rst_n = 1'b0;
        s_if.fcw_valid_i = 1'b0; s_if.fcw_i = '0;
        b_if.fcw_valid_i = 1'b0; b_if.fcw_i = '0;
        seen_ovs = 0; seen_baud = 0;
        @(negedge clk);

        // Reset state and default tick pattern (FCW 64: tick every 4 edges).
        cyc(0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        chk("rst_ovs", s_ovs, 0);
        chk("rst_baud", s_baud, 0);
        chk("rst_clk_o", s_clko, 1);
        chk("rst_fcw_o", s_fcw_o, S_RST);
        chk("rst_ready", s_if.fcw_ready_o, 1);
        b_rst_n = 1'b1;
        seen_ovs = 0; seen_baud = 0;
        repeat (3) cyc(1, 1, 0, 0, 0);
        chk("no_tick_before_edge4", seen_ovs, 0);
        cyc(1, 1, 0, 0, 0);
        chk("tick_at_edge4", s_ovs, 1);
        repeat (12) cyc(1, 1, 0, 0, 0);
        chk("ovs_count_16_edges", seen_ovs, 4);
        chk("baud_count_16_edges", seen_baud, 1);
        repeat (24) cyc(1, 1, 0, 0, 0);

        // FCW write at acc=128 holds off until the next overflow.
        repeat (2) cyc(1, 1, 0, 0, 0);
        cyc(1, 1, 0, 1, 32);
        chk("ready_low_pending", s_if.fcw_ready_o, 0);
        chk("old_fcw_in_use", s_fcw_o, 64);
        cyc(1, 1, 0, 0, 0);
        chk("fcw_applied_at_carry", s_fcw_o, 32);
        chk("ready_back_high", s_if.fcw_ready_o, 1);
        seen_ovs = 0;
        repeat (16) cyc(1, 1, 0, 0, 0);
        chk("ovs_count_fcw32", seen_ovs, 2);

        // Disabled write applies next edge; zero FCW does not deadlock.
        seen_ovs = 0;
        cyc(1, 0, 0, 1, 48);
        cyc(1, 0, 0, 0, 0);
        chk("disabled_apply", s_fcw_o, 48);
        chk("no_ticks_disabled", seen_ovs, 0);
        repeat (10) cyc(1, 1, 0, 0, 0);
        cyc(1, 0, 0, 1, 0);
        cyc(1, 0, 0, 0, 0);
        chk("zero_fcw_applied", s_fcw_o, 0);
        seen_ovs = 0;
        repeat (10) cyc(1, 1, 0, 0, 0);
        chk("zero_fcw_no_ticks", seen_ovs, 0);
        cyc(1, 1, 0, 1, 64);
        cyc(1, 1, 0, 0, 0);
        chk("zero_fcw_replaced", s_fcw_o, 64);
        repeat (8) cyc(1, 1, 0, 0, 0);

        // Phase clear coincident with a carry suppresses the tick.
        cyc(1, 1, 1, 0, 0);
        repeat (3) cyc(1, 1, 0, 0, 0);
        cyc(1, 1, 1, 0, 0);
        chk("clr_kills_ovs", s_ovs, 0);
        chk("clr_kills_baud", s_baud, 0);
        chk("clr_clk_high", s_clko, 1);
        seen_ovs = 0;
        repeat (3) cyc(1, 1, 0, 0, 0);
        chk("clr_no_early_tick", seen_ovs, 0);
        cyc(1, 1, 0, 0, 0);
        chk("clr_tick_edge4", s_ovs, 1);

        // Reset with a pending word and ovs_cnt=2.
        repeat (4) cyc(1, 1, 0, 0, 0);
        cyc(1, 1, 0, 1, 32);
        chk("mid_pending", s_if.fcw_ready_o, 0);
        chk("mid_clk_low", s_clko, 0);
        cyc(0, 1, 0, 0, 0);
        chk("mid_rst_fcw_o", s_fcw_o, S_RST);
        chk("mid_rst_ready", s_if.fcw_ready_o, 1);
        chk("mid_rst_clk_o", s_clko, 1);
        chk("mid_rst_ovs", s_ovs, 0);

        // Randomized traffic against the model (words kept within half scale).
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 199) != 0, $urandom_range(0, 9) != 0,
                $urandom_range(0, 49) == 0, $urandom_range(0, 4) == 0,
                int'($urandom_range(0, 128)));
        end

        // Long-run accuracy of the free-running large instance.
        repeat (27000) @(negedge clk);
        #1;
        exp_ovs = (b_edges * int'(B_RST)) >>> B_N;
        chk("accuracy_ovs_ticks", b_ovs_seen, exp_ovs);
        chk("accuracy_baud_ticks", b_baud_seen, exp_ovs / int'(B_OVS));
        chk("accuracy_clk_o", b_clko, (exp_ovs % int'(B_OVS)) < int'(B_OVS / 2));
        chk("big_fcw_o", b_fcw_o, B_RST);
        chk("big_ready", b_if.fcw_ready_o, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/acc_baud_gen.md
Name: acc_baud_gen

Overview:
Runtime-programmable phase-accumulator rate generator for the UART datapath. It produces an oversample tick (for RX sampling), a baud tick, and a ~50% duty baud-rate clock.
- FCW is loadable through a valid/ready handshake and switches glitch-free at an accumulator overflow boundary.
- A phase-clear input realigns the generator, e.g. on RX start-bit detection.
- Sits between the register interface and the UART TX/RX engines.

Parameters:
ACC_SIZE, 16, accumulator width N; resolution = Fclk/2^N.
OVS, 16, oversample ticks per baud period; even, >= 2.
FCW_RST, 151, FCW loaded at reset; range 0..2^(ACC_SIZE-1).

Ports:
clk_i  in  1  system clock.
rst_ni  in  1  synchronous reset, active low.
en_i  in  1  count enable; low freezes all state.
phase_clr_i  in  1  one-cycle pulse; clears accumulator and oversample counter.
fcw_i  in  ACC_SIZE  new frequency control word.
fcw_valid_i  in  1  fcw_i valid.
fcw_ready_o  out  1  no FCW update pending; a new word can be accepted.
fcw_o  out  ACC_SIZE  FCW currently in use.
ovs_tick_o  out  1  one-cycle pulse per accumulator overflow.
baud_tick_o  out  1  one-cycle pulse per OVS overflows.
clk_o  out  1  baud-rate clock, high for the first OVS/2 ticks of each period.

Behaviour:
Interface: one clock, clk_i. Reset is synchronous and active-low: rst_ni is sampled on the rising edge of clk_i.

Reset (rst_ni=0 at a rising edge of clk_i):
- acc=0, ovs_cnt=0, fcw_o=FCW_RST, pending=0.
- fcw_ready_o=1, ovs_tick_o=0, baud_tick_o=0, clk_o=1.
- Reset mid-operation discards any pending FCW and any tick in flight.

Accumulator:
- sum = {1'b0,acc} + fcw_o, ACC_SIZE+1 bits; carry = sum[ACC_SIZE].
- On each enabled edge, acc <= sum[ACC_SIZE-1:0] and ovs_tick_o <= carry.
- ovs_tick_o is registered: a carry computed at edge k is visible for the one cycle after edge k.

Oversample counter:
- ovs_cnt runs 0..OVS-1 and advances on carry, wrapping from OVS-1 to 0.
- baud_tick_o <= carry && ovs_cnt==OVS-1.
- clk_o <= (next ovs_cnt < OVS/2). clk_o is registered, so it is glitch-free.

FCW handshake:
- Transfer occurs when fcw_valid_i && fcw_ready_o. The word is latched into a shadow register, pending=1, fcw_ready_o=0.
- If en_i=0, the shadow is applied to fcw_o on the next edge instead.
- While en_i=1, the shadow is applied at the same edge where carry=1; pending then clears and fcw_ready_o returns high on that edge.
- fcw_valid_i while fcw_ready_o=0 is ignored; the source must hold it.
- With fcw_o=0 no carry ever occurs. A write while fcw_o=0 applies on the next edge. This avoids deadlock.
- FCW > 2^(ACC_SIZE-1) is accepted as-is. ovs_tick_o may then be high on back-to-back cycles. A simulation assertion flags this.

en_i=0:
- acc, ovs_cnt, clk_o hold.
- ovs_tick_o=0 and baud_tick_o=0 on the next edge.

phase_clr_i=1:
- acc<=0, ovs_cnt<=0, clk_o<=1.
- ovs_tick_o<=0 and baud_tick_o<=0, even if carry=1 that cycle; clear wins.
- Any pending FCW is applied at the same edge.
- Acts regardless of en_i.
- The first tick after a clear is at ceil(2^ACC_SIZE/FCW) enabled edges.

Simultaneous FCW handshake and carry:
- The new word is only latched into the shadow.
- It is applied at the next carry, not this one.

Decomposition:
Package acc_clk_pkg:
- constant function calc_fcw(fclk_hz, fout_hz, acc_size), returning the round-to-nearest of fout*OVS*2^N/fclk.
- Default localparams for common 50/100 MHz baud configurations.
- enum for clock-output mode, reserved for later.

Sub-module acc_phase_core:
- Accumulator plus FCW shadow/handshake; outputs carry and fcw_o.
- acc_baud_gen instantiates it and adds the ovs_cnt/baud/clk_o stage.

Test Plan:
1. Reset and defaults. ACC_SIZE=8, OVS=4, FCW_RST=64, en=1 after reset → ovs_tick_o high one cycle after enabled edges 4, 8, 12…; baud_tick_o after edge 16, 32; clk_o 8 cycles high, 8 low.
2. FCW handshake boundary. FCW=64; write fcw_i=32 at acc=128 → fcw_ready_o=0 until the carry edge; old spacing (4) until then, then 8-cycle spacing; fcw_o=32 from that edge.
3. Handshake vs en_i and zero FCW. en_i=0 write fcw_i=48 → applied next edge, no ticks while disabled. fcw_o=0 write 64 → applied next edge, ticking resumes.
4. phase_clr. Pulse coincident with a carry → no ovs_tick_o or baud_tick_o, clk_o=1, ovs_cnt=0; next ovs tick exactly 4 edges later (FCW=64).
5. Reset mid-operation. rst_ni low while pending=1 and ovs_cnt=2 → all outputs at reset values after one edge, fcw_o=FCW_RST, fcw_ready_o=1.
6. Accuracy. ACC_SIZE=16, FCW=151, 100 000 cycles → ovs tick count = floor(100000*151/65536) = 230 (±1); baud ticks = 14 for OVS=16.
